// File: rtl/tiny_riscv_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encoding,
// STATUS bit positions and register offsets.
package tiny_riscv_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 4;

    localparam logic [31:0] DATA_OFS   = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;

    // STATUS has a 4-bit count field; deeper FIFOs report 15.
    function automatic logic [3:0] sat_count(input logic [31:0] c);
        return (c > 32'd15) ? 4'd15 : c[3:0];
    endfunction

endpackage

// File: rtl/tiny_riscv_sync_fifo.sv
// Circular-buffer FIFO with synchronous reset. A push while full is accepted
// when a pop happens in the same cycle.
module tiny_riscv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tiny_riscv_uart_tx_periph.sv
// UART 8N1 transmitter on the processor data bus: stores to DATA are queued
// in a FIFO and serialised on o_UART_TX; STATUS is readable at BASE+4.
module tiny_riscv_uart_tx_periph #(
    parameter int          CLKS_PER_BIT = 217,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0040_0000
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [31:0] i_mem_addr,
    input  logic        i_read_strobe,
    input  logic [31:0] i_mem_write_data,
    input  logic [3:0]  i_mem_write_mask,
    output logic [31:0] o_mem_data,
    output logic        o_UART_TX
);
    import tiny_riscv_uart_pkg::*;

    localparam int             BW          = $clog2(CLKS_PER_BIT);
    localparam int             CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0]  BAUD_LOAD   = BW'(CLKS_PER_BIT - 1);
    localparam logic [31:0]    DATA_ADDR   = BASE_ADDR + DATA_OFS;
    localparam logic [31:0]    STATUS_ADDR = BASE_ADDR + STATUS_OFS;

    logic          sel_data;
    logic          sel_status;
    logic          data_write;
    logic          ovf_set;
    logic          ovf_clear;
    logic          overflow;
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;

    tx_state_t     state;
    logic [BW-1:0] baud_cnt;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic          tx_reg;

    logic          unused_bits;
    assign unused_bits = ^{i_mem_addr[1:0], i_mem_write_data[31:8],
                           i_mem_write_data[7:4], i_mem_write_data[2:0],
                           i_mem_write_mask[3:1]};

    assign sel_data   = (i_mem_addr[31:2] == DATA_ADDR[31:2]);
    assign sel_status = (i_mem_addr[31:2] == STATUS_ADDR[31:2]);
    assign data_write = sel_data && i_mem_write_mask[0];
    assign ovf_clear  = sel_status && i_mem_write_mask[0] && i_mem_write_data[3];
    assign pop        = (state == ST_IDLE) && !fifo_empty;
    assign ovf_set    = data_write && fifo_full && !pop;
    assign o_UART_TX  = tx_reg;

    tiny_riscv_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_Clk),
        .rst   (i_Rst),
        .push  (data_write),
        .pop   (pop),
        .din   (i_mem_write_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status                            = '0;
        status[STAT_BUSY]                 = (state != ST_IDLE);
        status[STAT_FULL]                 = fifo_full;
        status[STAT_EMPTY]                = fifo_empty;
        status[STAT_OVERFLOW]             = overflow;
        status[STAT_COUNT_LSB +: 4]       = sat_count(32'(fifo_count));
    end

    // Read data lives for exactly one cycle so it can be ORed with memory.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_mem_data <= '0;
            overflow   <= 1'b0;
        end else begin
            o_mem_data <= (i_read_strobe && sel_status) ? status : '0;
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            shift    <= '0;
            bit_idx  <= '0;
            tx_reg   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_reg <= 1'b1;
                    if (!fifo_empty) begin
                        shift    <= fifo_dout;
                        baud_cnt <= BAUD_LOAD;
                        tx_reg   <= 1'b0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_LOAD;
                        tx_reg   <= shift[0];
                        shift    <= {1'b0, shift[7:1]};
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_LOAD;
                        if (bit_idx == 3'd7) begin
                            tx_reg <= 1'b1;
                            state  <= ST_STOP;
                        end else begin
                            tx_reg  <= shift[0];
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == '0) begin
                        tx_reg <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                default: begin
                    tx_reg <= 1'b1;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
